// File: rtl/stream_demux_pkg.sv
// Shared types and sizing for the two-way stream demultiplexer.
// STREAM_DEMUX_SKID_EN selects 2-entry output buffers with a registered din_ready.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } route_state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

`ifdef STREAM_DEMUX_SKID_EN
    localparam int SKID_DEPTH = 2;
`else
    localparam int SKID_DEPTH = 1;
`endif

endpackage

// File: rtl/stream_demux2_if.sv
// Producer-side and consumer-side handshake bundle for stream_demux2.
// slave is the demux view; master is the view of whoever drives and consumes it.
interface stream_demux2_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_last;
    logic              din_ready;
    logic              sel;

    logic [DATA_W-1:0] dout_A;
    logic              dout_A_valid;
    logic              dout_A_last;
    logic              dout_A_ready;

    logic [DATA_W-1:0] dout_B;
    logic              dout_B_valid;
    logic              dout_B_last;
    logic              dout_B_ready;

    modport slave (
        input  din, din_valid, din_last, sel, dout_A_ready, dout_B_ready,
        output din_ready,
        output dout_A, dout_A_valid, dout_A_last,
        output dout_B, dout_B_valid, dout_B_last
    );

    modport master (
        output din, din_valid, din_last, sel, dout_A_ready, dout_B_ready,
        input  din_ready,
        input  dout_A, dout_A_valid, dout_A_last,
        input  dout_B, dout_B_valid, dout_B_last
    );
endinterface

// File: rtl/stream_slot.sv
// One output buffer of SKID_DEPTH entries (head register plus optional tail).
// With STREAM_DEMUX_SKID_EN push_ready is a pure register decode; otherwise it looks through out_ready.
module stream_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    output logic              push_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              head_last_q, head_last_d;
    logic [DATA_W-1:0] tail_data_q, tail_data_d;
    logic              tail_last_q, tail_last_d;
    logic              push;
    logic              pop;

`ifdef STREAM_DEMUX_SKID_EN
    assign push_ready = (count_q < 2'(SKID_DEPTH));
`else
    assign push_ready = (count_q == 2'd0) || out_ready;
`endif

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;
    assign pop       = out_valid && out_ready;
    assign push      = push_valid && push_ready;

    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_data_d = push_data;
                    head_last_d = push_last;
                end else if (SKID_DEPTH > 1) begin
                    tail_data_d = push_data;
                    tail_last_d = push_last;
                end
            end
            2'b01: begin
                count_d     = count_q - 2'd1;
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
            end
            2'b11: begin
                // Occupancy unchanged; the oldest entry leaves, the new one goes to the back.
                if (count_q == 2'd1) begin
                    head_data_d = push_data;
                    head_last_d = push_last;
                end else begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    if (SKID_DEPTH > 1) begin
                        tail_data_d = push_data;
                        tail_last_d = push_last;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
        end
    end

endmodule

// File: rtl/stream_demux2.sv
// Two-way packet demux: sel on a packet's first beat picks A or B until the last beat.
// STREAM_DEMUX_SKID_EN (see stream_slot) decouples din_ready from the consumers' ready.
module stream_demux2
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_demux2_if.slave  bus
);

    route_state_t state_q, state_d;
    chan_t        route_ch;
    logic         a_push_ready;
    logic         b_push_ready;
    logic         accept;

    always_comb begin
        route_ch = chan_t'(bus.sel);
        case (state_q)
            LOCK_A:  route_ch = CH_A;
            LOCK_B:  route_ch = CH_B;
            default: ;
        endcase
    end

    assign bus.din_ready = (route_ch == CH_B) ? b_push_ready : a_push_ready;
    assign accept        = bus.din_valid && bus.din_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // Single-beat packets never leave IDLE.
                if (accept && !bus.din_last)
                    state_d = (route_ch == CH_B) ? LOCK_B : LOCK_A;
            end
            LOCK_A, LOCK_B: begin
                if (accept && bus.din_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    stream_slot #(.DATA_W(DATA_W)) u_slot_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.din_valid && (route_ch == CH_A)),
        .push_data  (bus.din),
        .push_last  (bus.din_last),
        .push_ready (a_push_ready),
        .out_data   (bus.dout_A),
        .out_valid  (bus.dout_A_valid),
        .out_last   (bus.dout_A_last),
        .out_ready  (bus.dout_A_ready)
    );

    stream_slot #(.DATA_W(DATA_W)) u_slot_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.din_valid && (route_ch == CH_B)),
        .push_data  (bus.din),
        .push_last  (bus.din_last),
        .push_ready (b_push_ready),
        .out_data   (bus.dout_B),
        .out_valid  (bus.dout_B_valid),
        .out_last   (bus.dout_B_last),
        .out_ready  (bus.dout_B_ready)
    );

endmodule

// File: tb/tb_stream_demux2.sv
// Directed self-checking bench for stream_demux2; expected buffer depth follows STREAM_DEMUX_SKID_EN.
`timescale 1ns/1ps
module tb_stream_demux2;

    localparam int DATA_W = 8;
`ifdef STREAM_DEMUX_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    stream_demux2_if #(.DATA_W(DATA_W)) bus ();

    stream_demux2 #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s);
        bus.din_valid = v;
        bus.din       = d;
        bus.din_last  = l;
        bus.sel       = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        bus.dout_A_ready = 1'b1;
        bus.dout_B_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b exp=1", bus.din_ready); end
        checks++; if (bus.dout_A_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", bus.dout_A_valid); end
        checks++; if (bus.dout_B_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", bus.dout_B_valid); end
        checks++; if (bus.dout_A !== 8'h00) begin failures++; $display("FAIL reset_a_data got=%02h exp=00", bus.dout_A); end
        checks++; if (bus.dout_B !== 8'h00) begin failures++; $display("FAIL reset_b_data got=%02h exp=00", bus.dout_B); end
        checks++; if (bus.dout_A_last !== 1'b0) begin failures++; $display("FAIL reset_a_last got=%b exp=0", bus.dout_A_last); end
        checks++; if (bus.dout_B_last !== 1'b0) begin failures++; $display("FAIL reset_b_last got=%b exp=0", bus.dout_B_last); end
        tick();
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_b_packet();
        logic [7:0] d [3];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, d[i], (i == 2), 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (i < 3) begin
                checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL bpkt_din_ready beat=%0d got=%b exp=1", i, bus.din_ready); end
            end
            if (i > 0) begin
                checks++; if (bus.dout_B_valid !== 1'b1) begin failures++; $display("FAIL bpkt_b_valid cyc=%0d got=%b exp=1", i, bus.dout_B_valid); end
                checks++; if (bus.dout_B !== d[i-1]) begin failures++; $display("FAIL bpkt_b_data cyc=%0d got=%02h exp=%02h", i, bus.dout_B, d[i-1]); end
                checks++; if (bus.dout_B_last !== (i == 3)) begin failures++; $display("FAIL bpkt_b_last cyc=%0d got=%b exp=%b", i, bus.dout_B_last, (i == 3)); end
                $display("bpkt beat ch=B data=%02h last=%b", bus.dout_B, bus.dout_B_last);
            end
            checks++; if (bus.dout_A_valid !== 1'b0) begin failures++; $display("FAIL bpkt_a_idle cyc=%0d got=%b exp=0", i, bus.dout_A_valid); end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.dout_B_valid !== 1'b0) begin failures++; $display("FAIL bpkt_b_drained got=%b exp=0", bus.dout_B_valid); end
        tick();
    endtask

    task automatic test_sel_toggle();
        logic [7:0] d [5];
        logic       l [5];
        logic       s [5];
        logic       dst [5];
        d[0] = 8'hA1; l[0] = 1'b0; s[0] = 1'b1; dst[0] = 1'b1;
        d[1] = 8'hA2; l[1] = 1'b0; s[1] = 1'b0; dst[1] = 1'b1;
        d[2] = 8'hA3; l[2] = 1'b1; s[2] = 1'b0; dst[2] = 1'b1;
        d[3] = 8'hB1; l[3] = 1'b0; s[3] = 1'b0; dst[3] = 1'b0;
        d[4] = 8'hB2; l[4] = 1'b1; s[4] = 1'b1; dst[4] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b1, d[i], l[i], s[i]);
            else       drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (i < 5) begin
                checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL seltog_din_ready beat=%0d got=%b exp=1", i, bus.din_ready); end
            end
            if (i > 0) begin
                if (dst[i-1]) begin
                    checks++; if (bus.dout_B_valid !== 1'b1 || bus.dout_B !== d[i-1] || bus.dout_B_last !== l[i-1]) begin
                        failures++; $display("FAIL seltog_on_b cyc=%0d got v=%b d=%02h l=%b exp v=1 d=%02h l=%b", i, bus.dout_B_valid, bus.dout_B, bus.dout_B_last, d[i-1], l[i-1]);
                    end
                    checks++; if (bus.dout_A_valid !== 1'b0) begin failures++; $display("FAIL seltog_a_quiet cyc=%0d got=%b exp=0", i, bus.dout_A_valid); end
                    $display("seltog beat ch=B data=%02h", bus.dout_B);
                end else begin
                    checks++; if (bus.dout_A_valid !== 1'b1 || bus.dout_A !== d[i-1] || bus.dout_A_last !== l[i-1]) begin
                        failures++; $display("FAIL seltog_on_a cyc=%0d got v=%b d=%02h l=%b exp v=1 d=%02h l=%b", i, bus.dout_A_valid, bus.dout_A, bus.dout_A_last, d[i-1], l[i-1]);
                    end
                    checks++; if (bus.dout_B_valid !== 1'b0) begin failures++; $display("FAIL seltog_b_quiet cyc=%0d got=%b exp=0", i, bus.dout_B_valid); end
                    $display("seltog beat ch=A data=%02h", bus.dout_A);
                end
            end
            tick();
        end
    endtask

    task automatic test_a_stall();
        logic [7:0] d [4];
        logic       exp_ready;
        int         sent;
        int         got;
        d[0] = 8'h41; d[1] = 8'h42; d[2] = 8'h43; d[3] = 8'h44;
        sent = 0;
        got  = 0;
        bus.dout_A_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc == 6) bus.dout_A_ready = 1'b1;
            if (sent < 4) drive(1'b1, d[sent], (sent == 3), 1'b0);
            else          drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (cyc >= 1 && cyc <= 5) begin
                exp_ready = (sent < DEPTH);
                checks++; if (bus.din_ready !== exp_ready) begin failures++; $display("FAIL astall_din_ready cyc=%0d got=%b exp=%b", cyc, bus.din_ready, exp_ready); end
                checks++; if (bus.dout_A_valid !== 1'b1 || bus.dout_A !== d[0] || bus.dout_A_last !== 1'b0) begin
                    failures++; $display("FAIL astall_hold cyc=%0d got v=%b d=%02h l=%b exp v=1 d=%02h l=0", cyc, bus.dout_A_valid, bus.dout_A, bus.dout_A_last, d[0]);
                end
            end
            checks++; if (bus.dout_B_valid !== 1'b0) begin failures++; $display("FAIL astall_b_quiet cyc=%0d got=%b exp=0", cyc, bus.dout_B_valid); end
            if (bus.dout_A_valid && bus.dout_A_ready) begin
                checks++; if (bus.dout_A !== d[got] || bus.dout_A_last !== (got == 3)) begin
                    failures++; $display("FAIL astall_order idx=%0d got d=%02h l=%b exp d=%02h l=%b", got, bus.dout_A, bus.dout_A_last, d[got], (got == 3));
                end
                $display("astall beat ch=A data=%02h last=%b", bus.dout_A, bus.dout_A_last);
                got++;
            end
            if (bus.din_valid && bus.din_ready) sent++;
            tick();
        end
        checks++; if (got != 4) begin failures++; $display("FAIL astall_count got=%0d exp=4", got); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_a_full_b_flow();
        logic [7:0] d [3];
        d[0] = 8'h71; d[1] = 8'h72; d[2] = 8'h73;
        bus.dout_A_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(8'h60 + i), (i == DEPTH - 1), 1'b0);
            @(negedge clk);
            checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL afull_fill_ready beat=%0d got=%b exp=1", i, bus.din_ready); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, d[i], (i == 2), 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (i < 3) begin
                checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL afull_b_ready beat=%0d got=%b exp=1", i, bus.din_ready); end
            end
            if (i > 0) begin
                checks++; if (bus.dout_B_valid !== 1'b1 || bus.dout_B !== d[i-1]) begin
                    failures++; $display("FAIL afull_b_flow cyc=%0d got v=%b d=%02h exp v=1 d=%02h", i, bus.dout_B_valid, bus.dout_B, d[i-1]);
                end
                $display("afull beat ch=B data=%02h", bus.dout_B);
            end
            checks++; if (bus.dout_A_valid !== 1'b1 || bus.dout_A !== 8'h60) begin
                failures++; $display("FAIL afull_a_held cyc=%0d got v=%b d=%02h exp v=1 d=60", i, bus.dout_A_valid, bus.dout_A);
            end
            tick();
        end
        bus.dout_A_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            @(negedge clk);
            checks++; if (bus.dout_A_valid !== 1'b1 || bus.dout_A !== 8'(8'h60 + j) || bus.dout_A_last !== (j == DEPTH - 1)) begin
                failures++; $display("FAIL afull_a_drain idx=%0d got v=%b d=%02h l=%b exp v=1 d=%02h l=%b", j, bus.dout_A_valid, bus.dout_A, bus.dout_A_last, 8'(8'h60 + j), (j == DEPTH - 1));
            end
            $display("afull beat ch=A data=%02h", bus.dout_A);
            tick();
        end
        @(negedge clk);
        checks++; if (bus.dout_A_valid !== 1'b0) begin failures++; $display("FAIL afull_a_empty got=%b exp=0", bus.dout_A_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.dout_B_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i < 10) drive(1'b1, 8'(8'h50 + i), (i == 9), 1'b1);
            else        drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (i < 10) begin
                checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL b2b_din_ready beat=%0d got=%b exp=1", i, bus.din_ready); end
            end
            if (i > 0) begin
                checks++; if (bus.dout_B_valid !== 1'b1 || bus.dout_B !== 8'(8'h50 + i - 1) || bus.dout_B_last !== (i == 10)) begin
                    failures++; $display("FAIL b2b_out cyc=%0d got v=%b d=%02h l=%b exp v=1 d=%02h l=%b", i, bus.dout_B_valid, bus.dout_B, bus.dout_B_last, 8'(8'h50 + i - 1), (i == 10));
                end
                $display("b2b beat ch=B data=%02h last=%b", bus.dout_B, bus.dout_B_last);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.dout_B_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", bus.dout_B_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.dout_A_ready = 1'b0;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.dout_A_valid !== 1'b1 || bus.dout_A !== 8'h77) begin
            failures++; $display("FAIL rstmid_buffered got v=%b d=%02h exp v=1 d=77", bus.dout_A_valid, bus.dout_A);
        end
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.dout_A_valid !== 1'b0 || bus.dout_B_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_valids got a=%b b=%b exp a=0 b=0", bus.dout_A_valid, bus.dout_B_valid);
        end
        checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL rstmid_din_ready got=%b exp=1", bus.din_ready); end
        checks++; if (bus.dout_A !== 8'h00) begin failures++; $display("FAIL rstmid_a_data got=%02h exp=00", bus.dout_A); end
        tick();
        rst_n = 1'b1;
        bus.dout_A_ready = 1'b1;
        bus.dout_B_ready = 1'b1;
        drive(1'b1, 8'h88, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL rstmid_next_ready got=%b exp=1", bus.din_ready); end
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.dout_B_valid !== 1'b1 || bus.dout_B !== 8'h88 || bus.dout_B_last !== 1'b1) begin
            failures++; $display("FAIL rstmid_route_b got v=%b d=%02h l=%b exp v=1 d=88 l=1", bus.dout_B_valid, bus.dout_B, bus.dout_B_last);
        end
        checks++; if (bus.dout_A_valid !== 1'b0) begin failures++; $display("FAIL rstmid_a_quiet got=%b exp=0", bus.dout_A_valid); end
        $display("rstmid beat ch=B data=%02h", bus.dout_B);
        tick();
    endtask

    initial begin
        test_reset();
        test_b_packet();
        test_sel_toggle();
        test_a_stall();
        test_a_full_b_flow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
